branch_predictor_unit: RTL and testbench

//  Parametrised branch prediction unit for the RV32I cores: tagged direct-mapped BTB plus a

---
 rtl/branch_predictor_unit.sv | 91 +++++++++
 tb/tb_branch_predictor_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_unit.sv
// Purpose: tagged direct-mapped BTB plus saturating-counter PHT, bimodal or gshare indexed.
// Latency: lookup is combinational on pc; training takes effect on the edge after it is presented.
// Backpressure: none; a lookup and an update are accepted every cycle.
module branch_predictor_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int PHT_ENTRIES = 64,
    parameter int CNT_BITS    = 2,
    parameter int GHR_BITS    = 6,
    parameter bit GSHARE      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  hit,
    output logic                  pred,
    output logic [DATA_WIDTH-1:0] branch_target,
    output logic [DATA_WIDTH-1:0] pred_next_pc,
    input  logic                  update_predictor,
    input  logic                  update_btb,
    input  logic                  actually_taken,
    input  logic [DATA_WIDTH-1:0] resolved_pc,
    input  logic [DATA_WIDTH-1:0] resolved_pc_target
);

    localparam int BI_W  = $clog2(BTB_ENTRIES);
    localparam int PI_W  = $clog2(PHT_ENTRIES);
    localparam int TAG_W = DATA_WIDTH - 2 - BI_W;

    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};

    logic                  valid   [BTB_ENTRIES];
    logic [TAG_W-1:0]      tags    [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0] targets [BTB_ENTRIES];
    logic [CNT_BITS-1:0]   cnt     [PHT_ENTRIES];
    logic [GHR_BITS-1:0]   ghr;

    logic [BI_W-1:0]  look_bi, upd_bi;
    logic [TAG_W-1:0] look_tag, upd_tag;
    logic [PI_W-1:0]  look_pi, upd_pi, ghr_idx;
    logic [GHR_BITS:0] ghr_shift;
    logic             unused_low_bits;

    assign look_bi  = pc[2 +: BI_W];
    assign look_tag = pc[DATA_WIDTH-1 : 2+BI_W];
    assign upd_bi   = resolved_pc[2 +: BI_W];
    assign upd_tag  = resolved_pc[DATA_WIDTH-1 : 2+BI_W];

    // History occupies the low bits of the PHT index; bimodal mode simply masks it out.
    assign ghr_idx  = GSHARE ? PI_W'(ghr) : '0;
    assign look_pi  = pc[2 +: PI_W] ^ ghr_idx;
    assign upd_pi   = resolved_pc[2 +: PI_W] ^ ghr_idx;

    assign ghr_shift = {ghr, actually_taken};
    assign unused_low_bits = ^{pc[1:0], resolved_pc[1:0], ghr_shift[GHR_BITS]};

    // Outputs are forced to the not-predicted state while reset is held.
    always_comb begin
        hit           = rstn && valid[look_bi] && (tags[look_bi] == look_tag);
        pred          = rstn && cnt[look_pi][CNT_BITS-1];
        branch_target = hit ? targets[look_bi] : '0;
        pred_next_pc  = (hit && pred) ? branch_target : pc + DATA_WIDTH'(4);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < BTB_ENTRIES; i++) valid[i] <= 1'b0;
            for (int i = 0; i < PHT_ENTRIES; i++) cnt[i] <= CNT_INIT;
            ghr <= '0;
        end else begin
            if (update_btb) valid[upd_bi] <= 1'b1;
            if (update_predictor) begin
                if (actually_taken && cnt[upd_pi] != CNT_MAX)
                    cnt[upd_pi] <= cnt[upd_pi] + 1'b1;
                else if (!actually_taken && cnt[upd_pi] != '0)
                    cnt[upd_pi] <= cnt[upd_pi] - 1'b1;
                ghr <= ghr_shift[GHR_BITS-1:0];
            end
        end
    end

    // Tag and target payload need no reset: they are qualified by valid.
    always_ff @(posedge clk) begin
        if (rstn && update_btb) begin
            tags[upd_bi]    <= upd_tag;
            targets[upd_bi] <= resolved_pc_target;
        end
    end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Drives a bimodal and a gshare instance with identical stimulus and compares
// both against an array-based model of the prediction rules.
module tb_branch_predictor_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pc;
    logic        update_predictor, update_btb, actually_taken;
    logic [31:0] resolved_pc, resolved_pc_target;

    logic        hit_b, pred_b, hit_g, pred_g;
    logic [31:0] tgt_b, npc_b, tgt_g, npc_g;

    int checks = 0;
    int errors = 0;

    // Model state: BTB and history shared, one counter table per indexing mode.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_cnt   [2][64];
    int          m_ghr;

    always #5 clk = ~clk;

    branch_predictor_unit #(.GSHARE(1'b0)) dut_b (
        .clk(clk), .rstn(rstn), .pc(pc),
        .hit(hit_b), .pred(pred_b), .branch_target(tgt_b), .pred_next_pc(npc_b),
        .update_predictor(update_predictor), .update_btb(update_btb),
        .actually_taken(actually_taken), .resolved_pc(resolved_pc),
        .resolved_pc_target(resolved_pc_target)
    );

    branch_predictor_unit #(.GSHARE(1'b1)) dut_g (
        .clk(clk), .rstn(rstn), .pc(pc),
        .hit(hit_g), .pred(pred_g), .branch_target(tgt_g), .pred_next_pc(npc_g),
        .update_predictor(update_predictor), .update_btb(update_btb),
        .actually_taken(actually_taken), .resolved_pc(resolved_pc),
        .resolved_pc_target(resolved_pc_target)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int pht_index(input int gs, input logic [31:0] a);
        int idx;
        idx = int'((a / 4) % 64);
        if (gs != 0) idx = idx ^ m_ghr;
        return idx;
    endfunction

    task automatic model_check();
        int          bi;
        logic        e_hit;
        logic        e_pred [2];
        logic [31:0] e_tgt;
        bi    = int'((pc / 4) % 16);
        e_hit = rstn && m_valid[bi] && (m_tag[bi] == pc / 64);
        e_tgt = e_hit ? m_tgt[bi] : 32'h0;
        for (int g = 0; g < 2; g++)
            e_pred[g] = rstn && (m_cnt[g][pht_index(g, pc)] >= 2);
        check("hit_b",  {31'b0, hit_b},  {31'b0, e_hit});
        check("pred_b", {31'b0, pred_b}, {31'b0, e_pred[0]});
        check("tgt_b",  tgt_b, e_tgt);
        check("npc_b",  npc_b, (e_hit && e_pred[0]) ? e_tgt : pc + 32'd4);
        check("hit_g",  {31'b0, hit_g},  {31'b0, e_hit});
        check("pred_g", {31'b0, pred_g}, {31'b0, e_pred[1]});
        check("tgt_g",  tgt_g, e_tgt);
        check("npc_g",  npc_g, (e_hit && e_pred[1]) ? e_tgt : pc + 32'd4);
    endtask

    task automatic model_update();
        int bi, idx;
        if (!rstn) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            for (int g = 0; g < 2; g++)
                for (int i = 0; i < 64; i++) m_cnt[g][i] = 1;
            m_ghr = 0;
            return;
        end
        if (update_predictor) begin
            for (int g = 0; g < 2; g++) begin
                idx = pht_index(g, resolved_pc);
                if (actually_taken) m_cnt[g][idx] = (m_cnt[g][idx] < 3) ? m_cnt[g][idx] + 1 : 3;
                else                m_cnt[g][idx] = (m_cnt[g][idx] > 0) ? m_cnt[g][idx] - 1 : 0;
            end
            m_ghr = (m_ghr * 2 + int'(actually_taken)) % 64;
        end
        if (update_btb) begin
            bi = int'((resolved_pc / 4) % 16);
            m_valid[bi] = 1'b1;
            m_tag[bi]   = resolved_pc / 64;
            m_tgt[bi]   = resolved_pc_target;
        end
    endtask

    // Inputs change just after the falling edge; lookups are checked 1 time unit later.
    task automatic apply(input logic r, input logic [31:0] p, input logic up, input logic ub,
                         input logic t, input logic [31:0] rp, input logic [31:0] rt);
        rstn = r; pc = p; update_predictor = up; update_btb = ub;
        actually_taken = t; resolved_pc = rp; resolved_pc_target = rt;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic train(input logic [31:0] rp, input logic t);
        apply(1'b1, rp, 1'b1, 1'b0, t, rp, 32'h0);
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 19) == 0) return $urandom();
        a = ($urandom_range(0, 7) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        return a;
    endfunction

    initial begin
        @(negedge clk);
        // Reset asserted together with an update: the update must be dropped.
        apply(1'b0, 32'h40, 1'b1, 1'b1, 1'b1, 32'h40, 32'h100);
        tick();
        apply(1'b0, 32'h40, 1'b1, 1'b1, 1'b1, 32'h40, 32'h100);
        check("rst_npc", npc_b, 32'h44);
        tick();

        apply(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t1_hit",  {31'b0, hit_b},  32'd0);
        check("t1_pred", {31'b0, pred_b}, 32'd0);
        check("t1_npc",  npc_b, 32'h44);
        tick();

        // Same-cycle lookup sees the old state, new state one cycle later.
        apply(1'b1, 32'h40, 1'b1, 1'b1, 1'b1, 32'h40, 32'h100);
        check("t6_old_hit", {31'b0, hit_b}, 32'd0);
        tick();
        apply(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t2_hit",  {31'b0, hit_b},  32'd1);
        check("t2_pred", {31'b0, pred_b}, 32'd1);
        check("t2_npc",  npc_b, 32'h100);
        tick();

        apply(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h80, 32'h200);
        tick();
        apply(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t3_evicted", {31'b0, hit_b}, 32'd0);
        tick();
        apply(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t3_hit", {31'b0, hit_b}, 32'd1);
        check("t3_tgt", tgt_b, 32'h200);
        tick();

        repeat (5) train(32'h40, 1'b1);
        train(32'h40, 1'b0);
        apply(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t4_cnt2", {31'b0, pred_b}, 32'd1);
        tick();
        train(32'h40, 1'b0);
        apply(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t4_cnt1", {31'b0, pred_b}, 32'd0);
        tick();
        repeat (3) train(32'h40, 1'b0);
        train(32'h40, 1'b1);
        apply(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t4_floor", {31'b0, pred_b}, 32'd0);
        tick();

        apply(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("wrap_npc", npc_b, 32'h0);
        tick();

        // Gshare: history T,N,T = 5, so training 0x40 hits counter 16^5 = 21.
        apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        train(32'h1000, 1'b1);
        train(32'h1000, 1'b0);
        train(32'h1000, 1'b1);
        train(32'h40, 1'b1);
        // History is now 0b001011: pc 0x78 reads counter 30^11=21, pc 0x6C reads 27^11=16.
        apply(1'b1, 32'h78, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t5_idx21", {31'b0, pred_g}, 32'd1);
        tick();
        apply(1'b1, 32'h6C, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t5_idx16", {31'b0, pred_g}, 32'd0);
        tick();

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rp;
            rp = rand_addr();
            apply(($urandom_range(0, 99) != 0), rand_addr(),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) != 0, rp, $urandom());
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
